register_file_scoreboard: RTL and testbench
===========================================

// Module: register_file_scoreboard
// PURPOSE
//  Parametrised multi-read-port register file for the 32-bit MIPS datapath, with a pending-write scoreboard.
//  - Write-to-read bypass, optional hardwired zero register, synchronous clear.
//  - Per-register busy bits are set when decode issues an instruction that targets a register.
//  - Busy bits are cleared at writeback. Hazard logic reads them to decide stalls.
// PARAMETERS
//  DATA_W    32  register width in bits
//  DEPTH     32  number of registers; power of 2, >= 2
//  ADDR_W     5  log2(DEPTH)
//  NUM_RD     2  number of read ports, 1..4
//  ZERO_REG   1  1: register 0 always reads 0, ignores writes, is never busy; 0: register 0 is ordinary
// PORTS
//  clk          in   1               rising-edge clock
//  reset        in   1               synchronous, active-high
//  we           in   1               writeback enable
//  wa           in   ADDR_W          writeback address
//  wd           in   DATA_W          writeback data
//  ra           in   NUM_RD*ADDR_W   read addresses; port i = ra[i*ADDR_W +: ADDR_W]
//  rd           out  NUM_RD*DATA_W   read data, packed like ra
//  rd_busy      out  NUM_RD          1 = port i's register has a pending write
//  alloc_en     in   1               issue request: mark alloc_addr as pending
//  alloc_addr   in   ADDR_W          destination register being issued
//  alloc_ready  out  1               allocation accepted this cycle
//  pending_cnt  out  ADDR_W+1        number of busy registers
// BEHAVIOUR
//  - Reset (sync, reset=1 at posedge): all registers <= 0, all busy bits <= 0, pending_cnt <= 0.
//    - Reset overrides we and alloc_en in the same cycle.
//    - After reset: rd = 0, rd_busy = 0, alloc_ready = 1.
//  - Write: at posedge with we=1, reg[wa] <= wd and busy[wa] <= 0.
//    - A write to a register that is not busy is legal and simply updates it.
//  - Read: combinational, zero latency.
//    - Bypass: if we && wa==ra_i (and not the zero register), rd_i = wd and rd_busy_i = 0.
//    - Otherwise rd_i = reg[ra_i] and rd_busy_i = busy[ra_i].
//    - ZERO_REG=1 and ra_i==0: rd_i = 0 and rd_busy_i = 0, always.
//  - Allocation handshake: alloc_ready = ~busy[alloc_addr] | (we && wa==alloc_addr).
//    - alloc_ready is 1 for the zero register when ZERO_REG=1.
//    - alloc_en && alloc_ready: busy[alloc_addr] <= 1 at the posedge.
//    - alloc_en with alloc_ready=0: ignored; no state change. Issue logic stalls and retries.
//    - Zero register (ZERO_REG=1): the allocation is accepted but has no effect.
//  - Same-cycle write and alloc to the same address: data is written and busy ends at 1 (new producer wins).
//  - Same-cycle write and alloc to different addresses: both take effect.
//  - Reads in an alloc cycle see pre-edge busy state. Alloc is not bypassed to rd_busy.
//  - pending_cnt is registered and tracks popcount(busy) exactly:
//    - +1 for an accepted effective alloc that sets a bit which was 0.
//    - -1 for a write that clears a bit which was 1.
//    - Net 0 when both happen on the same address.
//    - Never exceeds DEPTH (or DEPTH-1 when ZERO_REG=1); never wraps.
//  - No multicycle operations: reset mid-stream simply clears everything on that edge.
// STRUCTURE
//  - Shared header mips_defs.vh holds:
//    - REG_ADDR_W, REG_DATA_W, ZERO_REG_IDX.
//    - Decode constants naming the read ports (RS_PORT=0, RT_PORT=1).
//  - One sub-module, reg_scoreboard.
//    - Owns the busy vector, alloc_ready and pending_cnt.
//    - Inputs: we, wa, alloc_en, alloc_addr, reset.
//    - Output: busy vector.
//  - The top level keeps the data array, the read muxes and the bypass logic.
// TESTING
//  - Reset: write reg5=0xDEADBEEF, then assert reset for 1 cycle -> ra0=5 reads 0; rd_busy=0; pending_cnt=0.
//  - Bypass: we=1, wa=7, wd=0x12345678, ra1=7 in the same cycle -> rd1=0x12345678 before the edge, rd_busy1=0.
//  - Zero register: we=1, wa=0, wd=0xFFFFFFFF, then alloc 0 -> ra0=0 reads 0; rd_busy0=0; pending_cnt=0.
//  - Scoreboard:
//    - alloc 9 -> next cycle rd_busy=1 for ra=9; pending_cnt=1.
//    - alloc 9 again -> alloc_ready=0, pending_cnt stays 1.
//    - Write 9 with 0xA5 -> busy 0, pending_cnt=0, reads 0xA5.
//  - Collision: busy[3]=1; we=1 wa=3 and alloc_en alloc_addr=3 in one cycle -> alloc_ready=1; reg3=wd; busy[3]=1; pending_cnt unchanged.
//  - Fill: allocate 1..31 on consecutive cycles (ZERO_REG=1) -> pending_cnt=31; every further alloc has alloc_ready=0.
//    - Also run NUM_RD=3, DATA_W=16 and check all three ports.

Source files
------------

// File: rtl/register_file_scoreboard_pkg.sv
// Shared constants for the MIPS register file: default geometry, the
// zero-register index and the decode-side names of the read ports.
package register_file_scoreboard_pkg;

  localparam int REG_DATA_W   = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int ZERO_REG_IDX = 0;

  // Read-port numbering used by decode: rs on port 0, rt on port 1.
  localparam int RS_PORT = 0;
  localparam int RT_PORT = 1;

endpackage

// File: rtl/register_file_scoreboard_reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set when decode
// issues a producer and cleared at writeback, plus a live popcount.
module reg_scoreboard
  import register_file_scoreboard_pkg::*;
#(
  parameter int DEPTH    = 1 << REG_ADDR_W,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic              alloc_en_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  output logic [DEPTH-1:0]  busy_o,
  output logic              alloc_ready_o,
  output logic [ADDR_W:0]   pending_cnt_o
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             alloc_is_zero;
  logic             eff_alloc;
  logic             set_new;
  logic             clr_old;

  // The zero register is never marked busy, so it is always ready.
  assign alloc_is_zero = (ZERO_REG != 0) && (alloc_addr_i == ADDR_W'(ZERO_REG_IDX));
  assign alloc_ready_o = ~busy_q[alloc_addr_i] | (we_i && (wa_i == alloc_addr_i));

  // Next busy vector and counter: writeback clears first, so a same-address
  // allocation in the same cycle leaves the new producer marked busy.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    busy_d    = busy_q;
    eff_alloc = alloc_en_i && alloc_ready_o && !alloc_is_zero;
    set_new   = eff_alloc && !busy_q[alloc_addr_i];
    clr_old   = we_i && busy_q[wa_i] && !(eff_alloc && (alloc_addr_i == wa_i));
    if (we_i)      busy_d[wa_i]         = 1'b0;
    if (eff_alloc) busy_d[alloc_addr_i] = 1'b1;
    cnt_d = cnt_q + {{ADDR_W{1'b0}}, set_new} - {{ADDR_W{1'b0}}, clr_old};
  end

  // Busy vector and pending count registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o        = busy_q;
  assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/register_file_scoreboard.sv
// Multi-read-port register file with write-to-read bypass, optional
// hardwired zero register and a pending-write scoreboard for hazard logic.
module register_file_scoreboard
  import register_file_scoreboard_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int DEPTH    = 1 << REG_ADDR_W,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        wa_i,
  input  logic [DATA_W-1:0]        wd_i,
  input  logic [NUM_RD*ADDR_W-1:0] ra_i,
  output logic [NUM_RD*DATA_W-1:0] rd_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     alloc_en_i,
  input  logic [ADDR_W-1:0]        alloc_addr_i,
  output logic                     alloc_ready_o,
  output logic [ADDR_W:0]          pending_cnt_o
);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_en;

  assign wr_en = we_i && !((ZERO_REG != 0) && (wa_i == ADDR_W'(ZERO_REG_IDX)));

  reg_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .we_i          (we_i),
    .wa_i          (wa_i),
    .alloc_en_i    (alloc_en_i),
    .alloc_addr_i  (alloc_addr_i),
    .busy_o        (busy),
    .alloc_ready_o (alloc_ready_o),
    .pending_cnt_o (pending_cnt_o)
  );

  // Register array: writeback port, cleared as a whole by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // NOTE: the array is reset because software may read registers before writing them.
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Read muxes: zero register first, then same-cycle writeback bypass, then the array.
  always_comb begin
    rd_o      = '0;
    rd_busy_o = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] a;
      a = ra_i[i*ADDR_W +: ADDR_W];
      if ((ZERO_REG != 0) && (a == ADDR_W'(ZERO_REG_IDX))) begin
        rd_o[i*DATA_W +: DATA_W] = '0;
      end else if (we_i && (wa_i == a)) begin
        rd_o[i*DATA_W +: DATA_W] = wd_i;
      end else begin
        rd_o[i*DATA_W +: DATA_W] = regs_q[a];
        rd_busy_o[i]             = busy[a];
      end
    end
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Bench for register_file_scoreboard: a default 32x32 two-port instance and
// a 16-bit three-port instance share stimulus and one reference model.
module tb_register_file_scoreboard;
  import register_file_scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        reset, we, alloc_en;
  logic [4:0]  wa, alloc_addr;
  logic [31:0] wd;
  logic [4:0]  ra [3];
  logic [9:0]  ra_a;
  logic [14:0] ra_b;

  logic [63:0] rd_a;
  logic [1:0]  busy_a;
  logic        ready_a;
  logic [5:0]  cnt_a;
  logic [47:0] rd_b;
  logic [2:0]  busy_b;
  logic        ready_b;
  logic [5:0]  cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: register contents and busy flags as plain arrays.
  logic [31:0] m_reg  [32];
  bit          m_busy [32];

  assign ra_a = {ra[1], ra[0]};
  assign ra_b = {ra[2], ra[1], ra[0]};

  always #5 clk = ~clk;

  register_file_scoreboard #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .clk_i(clk), .reset_i(reset), .we_i(we), .wa_i(wa), .wd_i(wd), .ra_i(ra_a),
    .rd_o(rd_a), .rd_busy_o(busy_a), .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr),
    .alloc_ready_o(ready_a), .pending_cnt_o(cnt_a));

  register_file_scoreboard #(.DATA_W(16), .DEPTH(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(1)) dut_b (
    .clk_i(clk), .reset_i(reset), .we_i(we), .wa_i(wa), .wd_i(wd[15:0]), .ra_i(ra_b),
    .rd_o(rd_b), .rd_busy_o(busy_b), .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr),
    .alloc_ready_o(ready_b), .pending_cnt_o(cnt_b));

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (we && wa == a) return wd;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (we && wa == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_ready(input logic [4:0] a);
    return !m_busy[a] || (we && wa == a);
  endfunction

  function automatic logic [5:0] exp_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return 6'(n);
  endfunction

  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic idle();
    reset = 1'b0; we = 1'b0; alloc_en = 1'b0;
  endtask

  // One clock: apply the spec rules to the model at the edge, return at negedge.
  task automatic tick();
    logic rdy;
    @(posedge clk);
    rdy = exp_ready(alloc_addr);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = 32'h0; m_busy[i] = 1'b0; end
    end else begin
      if (we && wa != 5'd0) m_reg[wa] = wd;
      if (we) m_busy[wa] = 1'b0;
      if (alloc_en && rdy && alloc_addr != 5'd0) m_busy[alloc_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; alloc_en = 1'b1; alloc_addr = 5'd12;
    tick();
    idle(); ra[0] = 5'd5; #1;
    n_checks++; if (rd_a[31:0] !== 32'hDEADBEEF) $display("FAIL pre_reset_rd0: got %h want deadbeef", rd_a[31:0]); else n_pass++;
    reset = 1'b1; we = 1'b1; wa = 5'd6; wd = 32'h1; alloc_en = 1'b1; alloc_addr = 5'd6;
    tick();
    idle(); ra[0] = 5'd5; ra[1] = 5'd6; alloc_addr = 5'd12; #1;
    n_checks++; if (rd_a !== 64'h0) $display("FAIL reset_rd_a: got %h want 0", rd_a); else n_pass++;
    n_checks++; if (rd_b[31:0] !== 32'h0) $display("FAIL reset_rd_b: got %h want 0", rd_b[31:0]); else n_pass++;
    n_checks++; if (busy_a !== 2'b00) $display("FAIL reset_busy: got %b want 00", busy_a); else n_pass++;
    n_checks++; if (cnt_a !== 6'd0 || cnt_b !== 6'd0) $display("FAIL reset_cnt: got %0d/%0d want 0", cnt_a, cnt_b); else n_pass++;
    n_checks++; if (ready_a !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_a); else n_pass++;
  endtask

  task automatic test_bypass();
    idle(); we = 1'b1; wa = 5'd7; wd = 32'h12345678; ra[0] = 5'd5; ra[1] = 5'd7; #1;
    n_checks++; if (rd_a[63:32] !== 32'h12345678) $display("FAIL bypass_rd1: got %h want 12345678", rd_a[63:32]); else n_pass++;
    n_checks++; if (busy_a[1] !== 1'b0) $display("FAIL bypass_busy1: got %b want 0", busy_a[1]); else n_pass++;
    n_checks++; if (rd_b[31:16] !== 16'h5678) $display("FAIL bypass_rd1_b: got %h want 5678", rd_b[31:16]); else n_pass++;
    tick();
    idle(); #1;
    n_checks++; if (rd_a[63:32] !== 32'h12345678) $display("FAIL written_rd1: got %h want 12345678", rd_a[63:32]); else n_pass++;
  endtask

  task automatic test_zero_reg();
    idle(); we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
    tick();
    idle(); alloc_en = 1'b1; alloc_addr = 5'd0; #1;
    n_checks++; if (ready_a !== 1'b1) $display("FAIL zero_ready: got %b want 1", ready_a); else n_pass++;
    tick();
    idle(); ra[0] = 5'd0; #1;
    n_checks++; if (rd_a[31:0] !== 32'h0) $display("FAIL zero_rd0: got %h want 0", rd_a[31:0]); else n_pass++;
    n_checks++; if (busy_a[0] !== 1'b0) $display("FAIL zero_busy0: got %b want 0", busy_a[0]); else n_pass++;
    n_checks++; if (cnt_a !== 6'd0) $display("FAIL zero_cnt: got %0d want 0", cnt_a); else n_pass++;
  endtask

  task automatic test_scoreboard();
    idle(); alloc_en = 1'b1; alloc_addr = 5'd9;
    tick();
    idle(); ra[0] = 5'd9; alloc_en = 1'b1; alloc_addr = 5'd9; #1;
    n_checks++; if (busy_a[0] !== 1'b1) $display("FAIL sb_busy9: got %b want 1", busy_a[0]); else n_pass++;
    n_checks++; if (cnt_a !== 6'd1) $display("FAIL sb_cnt1: got %0d want 1", cnt_a); else n_pass++;
    n_checks++; if (ready_a !== 1'b0 || ready_b !== 1'b0) $display("FAIL sb_realloc_ready: got %b/%b want 0", ready_a, ready_b); else n_pass++;
    tick();
    idle(); ra[0] = 5'd9; #1;
    n_checks++; if (cnt_a !== 6'd1) $display("FAIL sb_cnt_hold: got %0d want 1", cnt_a); else n_pass++;
    we = 1'b1; wa = 5'd9; wd = 32'hA5;
    tick();
    idle(); ra[0] = 5'd9; #1;
    n_checks++; if (busy_a[0] !== 1'b0) $display("FAIL sb_wb_busy: got %b want 0", busy_a[0]); else n_pass++;
    n_checks++; if (cnt_a !== 6'd0) $display("FAIL sb_wb_cnt: got %0d want 0", cnt_a); else n_pass++;
    n_checks++; if (rd_a[31:0] !== 32'hA5) $display("FAIL sb_wb_rd: got %h want a5", rd_a[31:0]); else n_pass++;
  endtask

  task automatic test_collision();
    idle(); alloc_en = 1'b1; alloc_addr = 5'd3;
    tick();
    idle(); we = 1'b1; wa = 5'd3; wd = 32'hCAFEF00D; alloc_en = 1'b1; alloc_addr = 5'd3; #1;
    n_checks++; if (ready_a !== 1'b1) $display("FAIL coll_ready: got %b want 1", ready_a); else n_pass++;
    tick();
    idle(); ra[RS_PORT] = 5'd3; ra[RT_PORT] = 5'd4; #1;
    n_checks++; if (rd_a[31:0] !== 32'hCAFEF00D) $display("FAIL coll_rd: got %h want cafef00d", rd_a[31:0]); else n_pass++;
    n_checks++; if (rd_b[15:0] !== 16'hF00D) $display("FAIL coll_rd_b: got %h want f00d", rd_b[15:0]); else n_pass++;
    n_checks++; if (busy_a[0] !== 1'b1) $display("FAIL coll_busy: got %b want 1", busy_a[0]); else n_pass++;
    n_checks++; if (cnt_a !== 6'd1) $display("FAIL coll_cnt: got %0d want 1", cnt_a); else n_pass++;
  endtask

  task automatic test_fill();
    idle(); reset = 1'b1;
    tick();
    for (int a = 1; a < 32; a++) begin
      idle(); alloc_en = 1'b1; alloc_addr = 5'(a);
      tick();
    end
    idle(); ra[0] = 5'd2; ra[1] = 5'd17; ra[2] = 5'd31; #1;
    n_checks++; if (cnt_a !== 6'd31 || cnt_b !== 6'd31) $display("FAIL fill_cnt: got %0d/%0d want 31", cnt_a, cnt_b); else n_pass++;
    n_checks++; if (busy_b !== 3'b111) $display("FAIL fill_busy_b: got %b want 111", busy_b); else n_pass++;
    n_checks++; if (rd_b !== 48'h0) $display("FAIL fill_rd_b: got %h want 0", rd_b); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      idle(); alloc_en = 1'b1; alloc_addr = 5'($urandom_range(1, 31)); #1;
      n_checks++; if (ready_a !== 1'b0 || ready_b !== 1'b0) $display("FAIL fill_ready a=%0d: got %b/%b want 0", alloc_addr, ready_a, ready_b); else n_pass++;
      tick();
    end
    idle(); #1;
    n_checks++; if (cnt_a !== 6'd31) $display("FAIL fill_cnt_hold: got %0d want 31", cnt_a); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] e;
    idle(); reset = 1'b1;
    tick();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      we = 1'($urandom_range(0, 1)); wa = pick_addr(); wd = $urandom;
      alloc_en = 1'($urandom_range(0, 1)); alloc_addr = pick_addr();
      for (int p = 0; p < 3; p++) ra[p] = pick_addr();
      #1;
      for (int p = 0; p < 3; p++) begin
        e = exp_rd(ra[p]);
        if (p < 2) begin
          n_checks++; if (rd_a[p*32 +: 32] !== e) $display("FAIL rnd_rd_a c=%0d p=%0d: got %h want %h", c, p, rd_a[p*32 +: 32], e); else n_pass++;
          n_checks++; if (busy_a[p] !== exp_busy(ra[p])) $display("FAIL rnd_busy_a c=%0d p=%0d: got %b want %b", c, p, busy_a[p], exp_busy(ra[p])); else n_pass++;
        end
        n_checks++; if (rd_b[p*16 +: 16] !== e[15:0]) $display("FAIL rnd_rd_b c=%0d p=%0d: got %h want %h", c, p, rd_b[p*16 +: 16], e[15:0]); else n_pass++;
        n_checks++; if (busy_b[p] !== exp_busy(ra[p])) $display("FAIL rnd_busy_b c=%0d p=%0d: got %b want %b", c, p, busy_b[p], exp_busy(ra[p])); else n_pass++;
      end
      n_checks++; if (ready_a !== exp_ready(alloc_addr) || ready_b !== exp_ready(alloc_addr)) $display("FAIL rnd_ready c=%0d: got %b/%b want %b", c, ready_a, ready_b, exp_ready(alloc_addr)); else n_pass++;
      n_checks++; if (cnt_a !== exp_cnt() || cnt_b !== exp_cnt()) $display("FAIL rnd_cnt c=%0d: got %0d/%0d want %0d", c, cnt_a, cnt_b, exp_cnt()); else n_pass++;
      tick();
    end
  endtask

  initial begin
    idle(); wa = '0; wd = '0; alloc_addr = '0;
    for (int p = 0; p < 3; p++) ra[p] = '0;
    reset = 1'b1;
    @(negedge clk);
    tick();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_collision();
    test_fill();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
